fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences instruction fetch: drives the instruction-memory address, resolves
//  fetch-time jumps, and buffers fetched instructions in a 2-entry queue toward decode.
//  Decode consumes them with a valid/ready handshake.
//  Sits between Instruction_Memory (combinational read) and the decode stage.
//  Replaces the free-running PC update with stall, redirect and halt control.
// PARAMETERS
//  PC_W        8  width of PC / memory address
//  INSTR_W     8  width of instruction code
//  IMEM_DEPTH  6  number of valid instruction-memory words; addresses >= depth are illegal
//  JUMP_BIT    7  instruction bit that marks a jump; target = zero-extended instr[5:0]
// PORTS
//  clk             in   1        clock, all state updates on rising edge
//  reset           in   1        asynchronous, active-low reset
//  imem_addr       out  PC_W     address to Instruction_Memory (= pc)
//  imem_rdata      in   INSTR_W  instruction at imem_addr, same cycle
//  redirect_valid  in   1        external PC redirect request (one-cycle pulse)
//  redirect_pc     in   PC_W     redirect target
//  halt_req        in   1        stop fetching (sticky until reset)
//  instr_valid     out  1        head of buffer holds an instruction
//  instr_ready     in   1        decode accepts head this cycle
//  instr_code      out  INSTR_W  head instruction
//  instr_pc        out  PC_W     PC of head instruction
//  pc              out  PC_W     next fetch address
//  halted          out  1        controller is in HALT
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, pc=0, buffer empty, instr_valid=0,
//    instr_code=0, instr_pc=0, halted=0.
//  - States: IDLE -> FETCH (unconditional, first edge after reset release; memory image is loaded then).
//    FETCH <-> HOLD: enter HOLD when the buffer is full and there is no pop; return to FETCH on a pop.
//    Any state except IDLE -> HALT on halt_req. HALT is terminal until reset.
//  - Fetch: in FETCH, if (!full || pop), push {imem_rdata, pc}, then update pc:
//    if imem_rdata[JUMP_BIT] then pc <= instr[5:0]; else pc <= pc+1.
//    pc+1 == IMEM_DEPTH wraps to 0.
//  - The jump instruction itself is pushed to decode; no bubble follows it.
//  - Pop: instr_valid && instr_ready. Push and pop in the same cycle when full is allowed;
//    occupancy stays 2.
//  - Latency: first instr_valid=1 after the 2nd rising edge following reset release.
//    After that, one instruction per cycle while instr_ready=1.
//  - Redirect (FETCH/HOLD): flush the buffer (instr_valid=0 next cycle) and set pc <= redirect_pc.
//    No push occurs that cycle. Redirect wins over a simultaneous fetch or pop.
//  - Illegal address: redirect_pc or jump target >= IMEM_DEPTH maps to 0.
//  - halt_req wins over redirect in the same cycle: state=HALT and halted=1 next cycle.
//    In HALT: no pushes, the buffer is not flushed, decode drains the remaining entries,
//    pc is frozen, and redirect is ignored.
//  - Reset mid-operation clears everything immediately, including a partially drained buffer.
//  - instr_code and instr_pc are 0 when the buffer is empty.
// STRUCTURE
//  - Package fetch_pkg holds: state enum {IDLE, FETCH, HOLD, HALT}, PC_W, INSTR_W and JUMP_BIT
//    defaults, and a next_pc function (jump/increment/wrap/illegal map).
//  - Sub-module fetch_buffer: 2-entry FIFO of {INSTR_W+PC_W} bits.
//    It has push, pop, flush, full and empty, plus the same async active-low reset.
//  - The top level holds the FSM, the pc register and the next_pc mux.
// TESTING (memory image 19,49,0B,C5,4B,19)
//  - Reset release, instr_ready=1 -> instr_pc sequence 0,1,2,3,5,0,1
//    (C5 jumps to 5; pc 5 wraps to 0); codes 19,49,0B,C5,19,19,49.
//  - instr_ready=0 from cycle 2 for 4 cycles -> 2 entries held (pc 0,1), HOLD state, pc=2 frozen.
//    On release, pops in order with no loss or duplication.
//  - Full buffer + pop in the same cycle -> push and pop both occur, occupancy stays 2,
//    and the order is preserved.
//  - redirect_valid with redirect_pc=4 while 2 entries are buffered ->
//    instr_valid=0 next cycle, then instr_pc=4, code 4B.
//  - redirect_pc=9 -> fetch resumes at pc 0.
//    halt_req together with redirect -> halted=1, redirect ignored, buffered entries drain.
//  - Assert reset mid-stream with a full buffer -> all outputs are at reset values
//    before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and PC arithmetic for the instruction fetch controller.
package fetch_pkg;

  localparam int PC_W       = 8;
  localparam int INSTR_W    = 8;
  localparam int IMEM_DEPTH = 6;
  localparam int JUMP_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Any address outside the populated memory is steered back to 0.
  function automatic logic [PC_W-1:0] legal_pc(input logic [PC_W-1:0] addr);
    return (addr >= PC_W'(IMEM_DEPTH)) ? '0 : addr;
  endfunction

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0]    cur_pc,
                                               input logic [INSTR_W-1:0] instr);
    logic [PC_W-1:0] inc;
    inc = cur_pc + 1'b1;
    if (instr[JUMP_BIT]) begin
      return legal_pc(PC_W'(instr[5:0]));
    end
    return legal_pc(inc);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO between fetch and decode; slot0 is always the head.
module fetch_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : slot0_q;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) slot0_d = din_i;
          else               slot1_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; only the slots shift.
          if (cnt_q == 2'd1) begin
            slot0_d = din_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: drives the PC, resolves fetch-time jumps, buffers instructions for decode.
module fetch_controller
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_code,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output state_t             fsm_state
);

  state_t                    state_q, state_d;
  logic [PC_W-1:0]           pc_q, pc_d;
  logic                      push, pop, flush, full, empty;
  logic [INSTR_W+PC_W-1:0]   head;

  // Decode handshake: a transfer happens on a rising edge where instr_valid
  // and instr_ready are both high; instr_valid never depends on instr_ready.
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = !empty;
  assign instr_code  = head[INSTR_W+PC_W-1:PC_W];
  assign instr_pc    = head[PC_W-1:0];
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALT);
  assign fsm_state   = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // Priority: halt, then redirect, then the normal fetch.
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = legal_pc(redirect_pc);
        end else if (!full || pop) begin
          push = 1'b1;
          pc_d = next_pc(pc_q, imem_rdata);
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = legal_pc(redirect_pc);
          state_d = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .W(INSTR_W + PC_W)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   ({imem_rdata, pc_q}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with an expected-transfer scoreboard.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic               clk;
  logic               reset;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt_req;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_code;
  logic [PC_W-1:0]    instr_pc;
  logic [PC_W-1:0]    pc;
  logic               halted;
  state_t             fsm_state;

  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_fails;

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_code     (instr_code),
    .instr_pc       (instr_pc),
    .pc             (pc),
    .halted         (halted),
    .fsm_state      (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory image 19,49,0B,C5,4B,19
  always_comb begin
    case (imem_addr)
      8'd0:    imem_rdata = 8'h19;
      8'd1:    imem_rdata = 8'h49;
      8'd2:    imem_rdata = 8'h0B;
      8'd3:    imem_rdata = 8'hC5;
      8'd4:    imem_rdata = 8'h4B;
      8'd5:    imem_rdata = 8'h19;
      default: imem_rdata = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted transfer must match the queue head.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_transfer: got code %0h pc %0h with empty queue", instr_code, instr_pc);
      end else begin
        check("transfer", {16'h0, instr_code, instr_pc}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic exp_push(input logic [7:0] code, input logic [7:0] p);
    exp_q.push_back({code, p});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  32'(instr_valid), 32'd0);
    check({tag, "_code"},   32'(instr_code),  32'd0);
    check({tag, "_ipc"},    32'(instr_pc),    32'd0);
    check({tag, "_pc"},     32'(pc),          32'd0);
    check({tag, "_addr"},   32'(imem_addr),   32'd0);
    check({tag, "_halted"}, 32'(halted),      32'd0);
    check({tag, "_state"},  32'(fsm_state),   32'(IDLE));
  endtask

  // Ends #1 after the posedge preceding edge 1 of the new run.
  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    instr_ready    = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset       = 1'b1;
    instr_ready = rdy;
  endtask

  initial begin
    n_checks       = 0;
    n_fails        = 0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    instr_ready    = 1'b0;

    // Free-running fetch with a jump and a wrap.
    do_reset(1'b1);
    exp_push(8'h19, 8'd0); exp_push(8'h49, 8'd1); exp_push(8'h0B, 8'd2);
    exp_push(8'hC5, 8'd3); exp_push(8'h19, 8'd5); exp_push(8'h19, 8'd0);
    exp_push(8'h49, 8'd1);
    step();
    @(negedge clk);
    check("lat_e1_valid", 32'(instr_valid), 32'd0);
    check("lat_e1_state", 32'(fsm_state), 32'(FETCH));
    step();
    @(negedge clk);
    check("lat_e2_valid", 32'(instr_valid), 32'd1);
    check("lat_e2_ipc", 32'(instr_pc), 32'd0);
    check("lat_e2_code", 32'(instr_code), 32'h19);
    repeat (7) step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Decode stalls: buffer fills and the controller holds.
    do_reset(1'b0);
    exp_push(8'h19, 8'd0); exp_push(8'h49, 8'd1);
    exp_push(8'h0B, 8'd2); exp_push(8'hC5, 8'd3);
    repeat (4) step();
    @(negedge clk);
    check("hold_state", 32'(fsm_state), 32'(HOLD));
    check("hold_pc", 32'(pc), 32'd2);
    check("hold_ipc", 32'(instr_pc), 32'd0);
    check("hold_valid", 32'(instr_valid), 32'd1);
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    check("hold_state2", 32'(fsm_state), 32'(HOLD));
    check("hold_pc2", 32'(pc), 32'd2);
    repeat (4) step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("hold_drained", 32'(exp_q.size()), 32'd0);

    // Full buffer with a pop: push and pop in the same cycle.
    do_reset(1'b0);
    exp_push(8'h19, 8'd0); exp_push(8'h49, 8'd1); exp_push(8'h0B, 8'd2);
    repeat (3) step();
    instr_ready = 1'b1;
    @(negedge clk);
    check("fullpop_state", 32'(fsm_state), 32'(FETCH));
    check("fullpop_ipc0", 32'(instr_pc), 32'd0);
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("fullpop_state2", 32'(fsm_state), 32'(FETCH));
    check("fullpop_ipc1", 32'(instr_pc), 32'd1);
    check("fullpop_pc", 32'(pc), 32'd3);
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    check("fullpop_hold", 32'(fsm_state), 32'(HOLD));
    step();
    @(negedge clk);
    check("fullpop_ipc2", 32'(instr_pc), 32'd2);
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("fullpop_ipc3", 32'(instr_pc), 32'd3);
    check("fullpop_drained", 32'(exp_q.size()), 32'd0);

    // Redirect with two entries buffered, illegal redirect, then halt.
    do_reset(1'b0);
    exp_push(8'h4B, 8'd4);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 8'd4;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_code", 32'(instr_code), 32'd0);
    check("redir_pc", 32'(pc), 32'd4);
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    check("redir_ipc", 32'(instr_pc), 32'd4);
    check("redir_code4", 32'(instr_code), 32'h4B);
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'd9;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("illegal_valid", 32'(instr_valid), 32'd0);
    check("illegal_pc", 32'(pc), 32'd0);
    step();
    @(negedge clk);
    check("illegal_ipc", 32'(instr_pc), 32'd0);
    check("illegal_code", 32'(instr_code), 32'h19);
    check("redir_drained", 32'(exp_q.size()), 32'd0);
    step();
    halt_req       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'd4;
    exp_push(8'h19, 8'd0); exp_push(8'h49, 8'd1);
    step();
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_state", 32'(fsm_state), 32'(HALT));
    check("halt_pc", 32'(pc), 32'd2);
    check("halt_ipc", 32'(instr_pc), 32'd0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 8'd3;
    @(negedge clk);
    check("halt_ipc1", 32'(instr_pc), 32'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("halt_empty_valid", 32'(instr_valid), 32'd0);
    check("halt_empty_code", 32'(instr_code), 32'd0);
    check("halt_frozen_pc", 32'(pc), 32'd2);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_drained", 32'(exp_q.size()), 32'd0);
    instr_ready = 1'b0;

    // Asynchronous reset with a full buffer.
    do_reset(1'b0);
    repeat (3) step();
    @(negedge clk);
    check("pre_reset_valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
